// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the a ##1 b |-> ##[1:MAX_DLY] c checker.
package seq_chk_pkg;

    localparam int LAT_W    = 4;
    localparam int MAX_PEND = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WAIT  = 2'd2
    } seq_chk_state_e;

    // Bit i of v holds the attempt that matched i samples ago; bit 0 is unused.
    function automatic logic [LAT_W-1:0] popcount(input logic [MAX_PEND:0] v);
        logic [LAT_W-1:0] r;
        r = '0;
        for (int i = 1; i <= MAX_PEND; i++) begin
            r = r + LAT_W'(v[i]);
        end
        return r;
    endfunction

    function automatic logic [LAT_W-1:0] msb_idx(input logic [MAX_PEND:0] v);
        logic [LAT_W-1:0] r;
        r = '0;
        for (int i = 1; i <= MAX_PEND; i++) begin
            if (v[i]) r = LAT_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_chk_sat_cnt.sv
// Saturating accumulator: adds inc each cycle and clamps at all-ones.
module seq_chk_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] inc,
    output logic [W-1:0] cnt
);

    logic [W:0] sum;

    assign sum = {1'b0, cnt} + {1'b0, inc};

    always_ff @(posedge clk) begin
        if (rst)         cnt <= '0;
        else if (sum[W]) cnt <= '1;
        else             cnt <= sum[W-1:0];
    end

endmodule

// File: rtl/seq_chk_fsm.sv
// Concurrent checker for a ##1 b |-> ##[1:MAX_DLY] c with pass/fail pulses and counters.
// Optional latency reporting is built only when SEQ_CHK_LAT_EN is defined.
module seq_chk_fsm
    import seq_chk_pkg::*;
#(
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    output logic                 match,
    output logic                 fail,
    output logic                 busy,
    output logic [CNT_W-1:0]     attempt_cnt,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [LAT_W-1:0]     lat,
    output logic                 lat_vld,
    output seq_chk_state_e       dbg_state
);

    logic               a_q;
    logic [MAX_DLY:1]   pend;
    logic [MAX_DLY:1]   pend_d;
    logic [MAX_PEND:0]  pend_ext;
    logic               hit;
    logic               any_pend;
    logic               match_d;
    logic               fail_d;
    logic [LAT_W-1:0]   pop;
    logic [CNT_W-1:0]   pass_inc;
    logic [CNT_W-1:0]   fail_inc;
    logic [CNT_W-1:0]   att_inc;

    always_comb begin
        pend_ext              = '0;
        pend_ext[MAX_DLY:1]   = pend;
        hit                   = a_q & b & en;
        any_pend              = |pend;
        pop                   = '0;
        match_d               = 1'b0;
        fail_d                = 1'b0;
        pend_d                = '0;
        if (c) begin
            // Every outstanding attempt is satisfied; the new one needs a later c.
            pop       = popcount(pend_ext);
            match_d   = any_pend;
            pend_d[1] = hit;
        end else begin
            fail_d    = pend[MAX_DLY];
            for (int k = 2; k <= MAX_DLY; k++) begin
                pend_d[k] = pend[k-1];
            end
            pend_d[1] = hit;
        end
    end

    always_comb begin
        if (int'(pop) > (2**CNT_W - 1)) pass_inc = '1;
        else                            pass_inc = CNT_W'(pop);
        fail_inc = CNT_W'(fail_d);
        att_inc  = CNT_W'(hit);
    end

    always_comb begin
        if (any_pend)  dbg_state = WAIT;
        else if (a_q)  dbg_state = ARMED;
        else           dbg_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= 1'b0;
            pend  <= '0;
            match <= 1'b0;
            fail  <= 1'b0;
        end else begin
            a_q   <= a;
            pend  <= pend_d;
            match <= match_d;
            fail  <= fail_d;
        end
    end

    assign busy = any_pend;

    seq_chk_sat_cnt #(.W(CNT_W)) u_att_cnt (
        .clk (clk), .rst (rst), .inc (att_inc),  .cnt (attempt_cnt)
    );
    seq_chk_sat_cnt #(.W(CNT_W)) u_pass_cnt (
        .clk (clk), .rst (rst), .inc (pass_inc), .cnt (pass_cnt)
    );
    seq_chk_sat_cnt #(.W(CNT_W)) u_fail_cnt (
        .clk (clk), .rst (rst), .inc (fail_inc), .cnt (fail_cnt)
    );

`ifdef SEQ_CHK_LAT_EN
    logic [LAT_W-1:0] lat_q;
    logic             lat_vld_q;

    // Latency of the oldest attempt resolved by this c.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q     <= '0;
            lat_vld_q <= 1'b0;
        end else begin
            lat_q     <= match_d ? msb_idx(pend_ext) : '0;
            lat_vld_q <= match_d;
        end
    end

    assign lat     = lat_q;
    assign lat_vld = lat_vld_q;
`else
    assign lat     = '0;
    assign lat_vld = 1'b0;
`endif

endmodule
